muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit implementing the eight RV32M operations for the execute stage of the pipeline. It sits beside the single-cycle ALU and accepts one operation at a time through a start/busy/done handshake. Results are held on `result` until the next accepted start. The hazard unit uses `busy` to stall the pipeline.

---
 rtl/muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Accepts one operation at a time through start/busy/done; the result is
// held on `result` until the next accepted start.
//
// Ports:
//   CLK     in   1     clock, rising edge
//   RESET   in   1     synchronous, active-high reset
//   start   in   1     request, sampled only in IDLE
//   op      in   3     funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   data1   in   XLEN  rs1 operand
//   data2   in   XLEN  rs2 operand
//   busy    out  1     high while not IDLE
//   done    out  1     one-cycle pulse, result valid
//   result  out  XLEN  registered result
//
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle combinational
// multiply; divides stay iterative either way.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int unsigned CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    state_e              state_q, state_d;
    op_e                 op_q, op_d, op_in;
    logic                sa_q, sa_d, sb_q, sb_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     bmag_q, bmag_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                a_sgn, b_sgn, sa, sb, div_zero, ovf, special, short_path;
    logic [XLEN-1:0]     amag, bmag, special_val;
    logic [XLEN:0]       sum, trial;

    assign op_in = op_e'(op);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0]   fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, amag} * {{XLEN{1'b0}}, bmag};
`endif

    // The datapath works on magnitudes; this applies the sign rules to the
    // raw magnitude product ({hi,lo}) or quotient/remainder ({rem,quot}).
    function automatic logic [XLEN-1:0] fix_result(input op_e o,
                                                   input logic [2*XLEN-1:0] a,
                                                   input logic s1,
                                                   input logic s2);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q;
        logic [XLEN-1:0]   r;
        p = (s1 ^ s2) ? -a : a;
        q = (s1 ^ s2) ? -a[XLEN-1:0] : a[XLEN-1:0];
        r = s1 ? -a[2*XLEN-1:XLEN] : a[2*XLEN-1:XLEN];
        case (o)
            OP_MUL:                       return a[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return p[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              return q;
            default:                      return r;
        endcase
    endfunction

    // Start-time decode: signedness, magnitudes and special cases.
    always_comb begin
        a_sgn    = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                   (op_in == OP_DIV)  || (op_in == OP_REM);
        b_sgn    = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        sa       = a_sgn & data1[XLEN-1];
        sb       = b_sgn & data2[XLEN-1];
        amag     = sa ? -data1 : data1;
        bmag     = sb ? -data2 : data2;
        div_zero = op_in[2] && (data2 == '0);
        ovf      = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (data1 == {1'b1, {(XLEN-1){1'b0}}}) && (data2 == '1);
        special  = div_zero | ovf;
        if (div_zero)
            special_val = ((op_in == OP_DIV) || (op_in == OP_DIVU)) ? '1 : data1;
        else
            special_val = (op_in == OP_DIV) ? data1 : '0;
`ifdef MULDIV_FAST_MUL_EN
        short_path = special | ~op_in[2];
`else
        short_path = special;
`endif
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = short_path ? DONE : CALC;
            CALC:    if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        result = result_q;
    end

    // Datapath next-state
    always_comb begin
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        bmag_d   = bmag_q;
        result_d = result_q;
        sum      = '0;
        trial    = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op_in;
                    sa_d   = sa;
                    sb_d   = sb;
                    bmag_d = bmag;
                    cnt_d  = CW'(XLEN);
                    acc_d  = {{XLEN{1'b0}}, amag};
                    if (special)
                        result_d = special_val;
`ifdef MULDIV_FAST_MUL_EN
                    else if (!op_in[2])
                        result_d = fix_result(op_in, fast_prod, sa, sb);
`endif
                end
            end
            CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (!op_q[2]) begin
                    // Shift-add: multiplier bits leave acc[0], partial
                    // product (with carry) enters from the top.
                    sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                            {1'b0, (acc_q[0] ? bmag_q : {XLEN{1'b0}})};
                    acc_d = {sum, acc_q[XLEN-1:1]};
                end else begin
                    // Restoring step on {rem,quot}: the shifted partial
                    // remainder is always < 2*divisor, so XLEN+1 bits suffice.
                    trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, bmag_q};
                    if (!trial[XLEN])
                        acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                end
                if (cnt_q == CW'(1))
                    result_d = fix_result(op_q, acc_d, sa_q, sb_q);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            op_q     <= OP_MUL;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            bmag_q   <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            bmag_q   <= bmag_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed RV32M cases plus randomized operations
// checked through an expected-result queue drained by a done monitor.
module tb_muldiv_unit;
    localparam int unsigned XLEN = 32;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data1, data2;
    logic        busy, done;
    logic [31:0] result;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .op(op),
        .data1(data1), .data2(data2),
        .busy(busy), .done(done), .result(result)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int unsigned when;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    localparam logic [31:0] MINV = 32'h8000_0000;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, got, exp);
    endtask

    // Reference model straight from the RV32M rules using 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      as_, bs_, au, bu;
        logic [63:0] p;
        as_ = longint'($signed(a));
        bs_ = longint'($signed(b));
        au  = longint'({32'b0, a});
        bu  = longint'({32'b0, b});
        case (o)
            3'd0: begin p = as_ * bs_;            return p[31:0];  end
            3'd1: begin p = as_ * bs_;            return p[63:32]; end
            3'd2: begin p = as_ * bu;             return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return a;
                p = as_ / bs_; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = au / bu; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
                p = as_ % bs_; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = au % bu; return p[31:0];
            end
        endcase
    endfunction

    // Cycles from the accepting edge to the edge that raises done.
    function automatic int unsigned latency(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        if (o[2] && (b == 0)) return 0;
        if ((o == 3'd4 || o == 3'd6) && a == MINV && b == 32'hFFFF_FFFF) return 0;
`ifdef MULDIV_FAST_MUL_EN
        if (!o[2]) return 0;
`endif
        return XLEN;
    endfunction

    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge CLK);
        while (busy && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (busy) begin
            n_checks++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", n);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string nm);
        exp_t e;
        wait_idle();
        op = o; data1 = a; data2 = b; start = 1'b1;
        @(posedge CLK); #1;
        e.res  = exp;
        e.when = cyc + latency(o, a, b);
        e.name = nm;
        sb_q.push_back(e);
        check({nm, "_busy"}, {31'b0, busy}, 32'd1);
        // Post-acceptance input changes must not affect the operation.
        start = 1'b0; op = 3'($urandom); data1 = $urandom; data2 = $urandom;
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge CLK) begin
        exp_t e;
        if (!RESET && done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
            end else begin
                e = sb_q.pop_front();
                check(e.name, result, e.res);
                check({e.name, "_time"}, 32'(cyc), 32'(e.when));
            end
        end
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return MINV;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int unsigned n;
        logic [2:0]  o;
        logic [31:0] a, b;

        RESET = 1'b1; start = 1'b0; op = '0; data1 = '0; data2 = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_busy",   {31'b0, busy}, 32'd0);
        check("reset_done",   {31'b0, done}, 32'd0);
        check("reset_result", result,        32'd0);
        RESET = 1'b0;

        issue(3'd0, 32'd7,       32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
        issue(3'd1, MINV,        MINV,          32'h4000_0000, "mulh_min_min");
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ff");
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff");
        issue(3'd4, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, "div_m7_2");
        issue(3'd6, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, "rem_m7_2");
        issue(3'd5, 32'd100,     32'd7,         32'd14,        "divu_100_7");
        issue(3'd7, 32'd100,     32'd7,         32'd2,         "remu_100_7");
        issue(3'd4, 32'd5,       32'd0,         32'hFFFF_FFFF, "div_by_zero");
        issue(3'd7, 32'd5,       32'd0,         32'd5,         "remu_by_zero");
        issue(3'd4, MINV,        32'hFFFF_FFFF, MINV,          "div_ovf");
        issue(3'd6, MINV,        32'hFFFF_FFFF, 32'd0,         "rem_ovf");

        // A start pulse during CALC must be ignored.
        issue(3'd0, 32'd2, 32'd3, 32'd6, "mul_busy_protect");
`ifndef MULDIV_FAST_MUL_EN
        repeat (5) @(negedge CLK);
        op = 3'd4; data1 = 32'd100; data2 = 32'd7; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
`endif

        // Reset in the middle of a divide discards it without a done pulse.
        issue(3'd5, 32'd1000, 32'd7, 32'd142, "divu_aborted");
        repeat (10) @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK); #1;
        check("midreset_busy",   {31'b0, busy}, 32'd0);
        check("midreset_done",   {31'b0, done}, 32'd0);
        check("midreset_result", result,        32'd0);
        sb_q.delete();
        @(negedge CLK);
        RESET = 1'b0;
        repeat (40) @(negedge CLK);
        issue(3'd5, 32'd9, 32'd3, 32'd3, "divu_after_reset");

        for (int i = 0; i < 150; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            issue(o, a, b, ref_model(o, a, b), $sformatf("rand%0d_op%0d", i, o));
        end

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
